switch_code_decoder: RTL and testbench

Receive-side decoder for the 2-bit line code produced by the team's switch-literal state encoder: `2'h1` carries a 0 bit, `2'h3` carries a 1 bit, `2'h0` is idle, and `2'h2` is illegal. The block accepts one symbol per cycle over a valid/ready handshake and deserialises data bits LSB-first into WIDTH-bit words. Each completed word is presented on a valid/ready output port. Framing and illegal-symbol errors are flagged and counted.

---
 rtl/switch_code_decoder.sv | 126 ++++++++++++
 tb/tb_switch_code_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_code_decoder.sv
// switch_code_decoder
//   Receive-side decoder for the 2-bit switch line code. Symbol 1 carries a
//   0 bit, 3 carries a 1 bit, 0 is idle and 2 is illegal. Data bits are
//   deserialised LSB-first into WIDTH-bit words, and each finished word is
//   offered on a valid/ready output port. Framing errors (idle mid-word) and
//   illegal symbols raise a one-cycle err pulse and bump a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sym_valid  sym carries a symbol this cycle
//   sym        line symbol (1=bit0, 3=bit1, 0=idle, 2=illegal)
//   sym_ready  decoder accepts a symbol this cycle (IDLE/RECV)
//   out_valid  out_data holds a completed word (HOLD)
//   out_ready  downstream accepts the word
//   out_data   decoded word, bit 0 = first received bit
//   err        one-cycle error pulse (ERR)
//   err_count  saturating error count
//   busy       word partially received or held (RECV/HOLD)
module switch_code_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_valid,
  input  logic [1:0]       sym,
  output logic             sym_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic [7:0]       err_count,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_HOLD,
    S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] count;

  logic accepted;
  logic is_data;
  logic is_illegal;
  logic last_bit;
  logic [WIDTH-1:0] shreg_ins;

  // Symbols 1 and 3 both have bit 0 set; bit 1 then carries the data value.
  assign accepted   = sym_valid && sym_ready;
  assign is_data    = sym[0];
  assign is_illegal = (sym == 2'h2);
  assign last_bit   = (count == LAST);
  assign shreg_ins  = shreg | (WIDTH'(sym[1]) << count);

  assign sym_ready = (state == S_IDLE) || (state == S_RECV);
  assign out_valid = (state == S_HOLD);
  assign err       = (state == S_ERR);
  assign busy      = (state == S_RECV) || (state == S_HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accepted) begin
          if (is_data)         state_nxt = S_RECV;
          else if (is_illegal) state_nxt = S_ERR;
        end
      end
      S_RECV: begin
        if (accepted) begin
          if (!is_data)      state_nxt = S_ERR;  // idle = framing error
          else if (last_bit) state_nxt = S_HOLD;
        end
      end
      S_HOLD: if (out_ready) state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      count     <= '0;
      out_data  <= '0;
      err_count <= '0;
    end else begin
      if (state_nxt == S_ERR && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      // shreg and count are zero whenever IDLE is entered, so the first
      // bit lands at position 0 through the same insert path as the rest.
      if (accepted && is_data) begin
        if (last_bit) begin
          out_data <= shreg_ins;
          shreg    <= '0;
          count    <= '0;
        end else begin
          shreg <= shreg_ins;
          count <= count + 1'b1;
        end
      end else if (state_nxt == S_ERR || state_nxt == S_IDLE) begin
        shreg <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_switch_code_decoder.sv
// Testbench for switch_code_decoder (WIDTH=8). A behavioural model keeps the
// received bits in a queue and the pending word/error as plain flags; each
// scenario task drives symbols cycle by cycle and compares DUT outputs.
module tb_switch_code_decoder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sym_valid;
  logic [1:0]   sym;
  logic         sym_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         err;
  logic [7:0]   err_count;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  bit           mq[$];
  bit           m_hold;
  bit           m_err;
  logic [W-1:0] m_word;
  logic [7:0]   m_errcnt;

  switch_code_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_ready (sym_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model over the same edge, and
  // return at the following negedge with post-edge outputs settled.
  task automatic tick(input logic v, input logic [1:0] s, input logic r,
                      input logic rs = 1'b0);
    logic [W-1:0] w;
    sym_valid = v;
    sym       = s;
    out_ready = r;
    rst       = rs;
    if (rs) begin
      mq.delete();
      m_hold = 0; m_err = 0; m_word = '0; m_errcnt = '0;
    end else if (m_err) begin
      m_err = 0;
    end else if (m_hold) begin
      if (r) m_hold = 0;
    end else if (v) begin
      if (s == 2'd1 || s == 2'd3) begin
        mq.push_back(s == 2'd3);
        if (mq.size() == W) begin
          w = '0;
          for (int i = 0; i < W; i++) w[i] = mq[i];
          m_word = w;
          m_hold = 1;
          mq.delete();
        end
      end else if (s == 2'd2 || mq.size() != 0) begin
        m_err = 1;
        mq.delete();
        if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int i = 0; i < W; i++) tick(1'b1, w[i] ? 2'd3 : 2'd1, r);
  endtask

  task automatic do_reset();
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (sym_ready !== 1'b1) begin n_err++; $display("FAIL reset_sym_ready: got %b want 1", sym_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_chk++; if (err_count !== 8'h00) begin n_err++; $display("FAIL reset_err_count: got %h want 00", err_count); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_clean_word();
    logic [1:0] syms [W] = '{2'd3, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3};
    for (int i = 0; i < W; i++) begin
      tick(1'b1, syms[i], 1'b1);
      if (i == W - 2) begin
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clean_early_valid: got %b want 0", out_valid); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL clean_busy: got %b want 1", busy); end
      end
    end
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL clean_valid: got %b want 1", out_valid); end
    n_chk++; if (out_data !== 8'h89) begin n_err++; $display("FAIL clean_data: got %h want 89", out_data); end
    n_chk++; if (sym_ready !== 1'b0) begin n_err++; $display("FAIL clean_hs_ready: got %b want 0", sym_ready); end
    tick(1'b0, 2'd0, 1'b1);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clean_valid_drop: got %b want 0", out_valid); end
    n_chk++; if (err_count !== 8'h00) begin n_err++; $display("FAIL clean_err_count: got %h want 00", err_count); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w2;
    send_word(8'h89, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 2'd3, 1'b0);  // held symbol must not be consumed
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'h89) begin n_err++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=89", out_valid, out_data); end
      n_chk++; if (sym_ready !== 1'b0) begin n_err++; $display("FAIL bp_sym_ready: got %b want 0", sym_ready); end
    end
    tick(1'b1, 2'd3, 1'b1);
    n_chk++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, sym_ready); end
    w2 = W'($urandom);
    send_word(w2, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_data !== w2) begin n_err++; $display("FAIL bp_next_word: got v=%b d=%h want v=1 d=%h", out_valid, out_data, w2); end
    tick(1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_framing();
    logic [W-1:0] w;
    tick(1'b1, 2'd3, 1'b1);
    tick(1'b1, 2'd1, 1'b1);
    tick(1'b1, 2'd3, 1'b1);
    tick(1'b1, 2'd0, 1'b1);
    n_chk++; if (err !== 1'b1) begin n_err++; $display("FAIL frame_err: got %b want 1", err); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_busy: got %b want 0", busy); end
    tick(1'b0, 2'd0, 1'b1);
    n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL frame_err_len: got %b want 0", err); end
    n_chk++; if (err_count !== 8'd1) begin n_err++; $display("FAIL frame_err_count: got %h want 01", err_count); end
    w = W'($urandom);
    send_word(w, 1'b1);
    n_chk++; if (out_valid !== 1'b1 || out_data !== w) begin n_err++; $display("FAIL frame_next_word: got v=%b d=%h want v=1 d=%h", out_valid, out_data, w); end
    tick(1'b0, 2'd0, 1'b1);
  endtask

  task automatic test_illegal();
    int pulses = 0;
    bit saw_valid = 0;
    logic [1:0] seq [6] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
    do_reset();
    foreach (seq[i]) begin
      tick(1'b1, seq[i], 1'b1);
      if (err) pulses++;
      if (out_valid) saw_valid = 1;
    end
    tick(1'b0, 2'd0, 1'b1);
    n_chk++; if (pulses != 2) begin n_err++; $display("FAIL illegal_pulses: got %0d want 2", pulses); end
    n_chk++; if (err_count !== 8'd2) begin n_err++; $display("FAIL illegal_err_count: got %h want 02", err_count); end
    n_chk++; if (saw_valid) begin n_err++; $display("FAIL illegal_out_valid: got 1 want 0"); end
  endtask

  task automatic test_gapped();
    logic [W-1:0] w;
    logic [7:0] cnt0;
    w = W'($urandom);
    cnt0 = err_count;
    for (int i = 0; i < W; i++) begin
      tick(1'b0, 2'd0, 1'b1);
      n_chk++; if (err !== 1'b0) begin n_err++; $display("FAIL gap_err: got %b want 0", err); end
      tick(1'b1, w[i] ? 2'd3 : 2'd1, 1'b1);
    end
    n_chk++; if (out_valid !== 1'b1 || out_data !== w) begin n_err++; $display("FAIL gap_word: got v=%b d=%h want v=1 d=%h", out_valid, out_data, w); end
    tick(1'b0, 2'd0, 1'b1);
    n_chk++; if (err_count !== cnt0) begin n_err++; $display("FAIL gap_err_count: got %h want %h", err_count, cnt0); end
  endtask

  task automatic test_saturation_reset();
    for (int i = 0; i < 520; i++) tick(1'b1, 2'd2, 1'b1);
    n_chk++; if (err_count !== 8'hFF) begin n_err++; $display("FAIL sat_err_count: got %h want ff", err_count); end
    tick(1'b1, 2'd2, 1'b1);
    tick(1'b1, 2'd2, 1'b1);
    n_chk++; if (err_count !== 8'hFF) begin n_err++; $display("FAIL sat_hold: got %h want ff", err_count); end
    tick(1'b0, 2'd0, 1'b1);
    tick(1'b1, 2'd3, 1'b1);
    tick(1'b1, 2'd1, 1'b1);
    tick(1'b1, 2'd3, 1'b1, 1'b1);
    n_chk++; if (err_count !== 8'h00 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL midword_reset: got cnt=%h busy=%b v=%b err=%b want 00 0 0 0", err_count, busy, out_valid, err);
    end
    send_word(8'hA5, 1'b0);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    n_chk++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_reset: got v=%b busy=%b want 0 0", out_valid, busy); end
    tick(1'b0, 2'd0, 1'b0);
    n_chk++; if (sym_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", sym_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
      n_chk++;
      if (sym_ready !== (!m_hold && !m_err) || out_valid !== m_hold || err !== m_err ||
          err_count !== m_errcnt || busy !== (m_hold || mq.size() != 0) ||
          (m_hold && out_data !== m_word)) begin
        n_err++;
        $display("FAIL random_cycle%0d: got rdy=%b v=%b d=%h err=%b cnt=%h busy=%b want rdy=%b v=%b d=%h err=%b cnt=%h busy=%b",
                 n, sym_ready, out_valid, out_data, err, err_count, busy,
                 !m_hold && !m_err, m_hold, m_word, m_err, m_errcnt, m_hold || mq.size() != 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sym_valid = 1'b0; sym = 2'd0; out_ready = 1'b0;
    m_hold = 0; m_err = 0; m_word = '0; m_errcnt = '0;
    @(negedge clk);
    test_reset();
    test_clean_word();
    test_backpressure();
    test_framing();
    test_illegal();
    test_gapped();
    test_saturation_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
